// File: rtl/chip8_sprite_blitter.sv
// CHIP-8 sprite blitter: XOR-draws sprites into a 1-bpp framebuffer RAM by
// read-modify-write, reports pixel collision, and zero-fills the buffer for CLS.
module chip8_sprite_blitter #(
  parameter int FB_W    = 64,
  parameter int FB_H    = 32,
  parameter int FB_BASE = 0,
  parameter bit WRAP    = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        clear,
  input  logic [5:0]  x,
  input  logic [4:0]  y,
  input  logic [3:0]  n,
  input  logic [11:0] i_addr,
  output logic [11:0] spr_addr,
  input  logic [7:0]  spr_data,
  output logic [9:0]  fb_addr,
  input  logic [7:0]  fb_rdata,
  output logic [7:0]  fb_wdata,
  output logic        fb_we,
  output logic        busy,
  output logic        done,
  output logic        collision
);

  localparam int ROW_BYTES = FB_W / 8;
  localparam int FB_BYTES  = FB_W * FB_H / 8;
  localparam logic [9:0] CLR_FIRST = 10'(FB_BASE);
  localparam logic [9:0] CLR_LAST  = 10'(FB_BASE + FB_BYTES - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_CLR,
    S_ROW_FETCH,
    S_ROW_WAIT,
    S_L_RD,
    S_L_WAIT,
    S_L_WR,
    S_R_RD,
    S_R_WAIT,
    S_R_WR,
    S_FIN
  } state_e;

  state_e      state_q, state_d;
  logic [11:0] i_q, i_d;
  logic [3:0]  n_q, n_d;
  logic [3:0]  r_q, r_d;
  logic [4:0]  y0_q, y0_d;
  logic [2:0]  col_q, col_d;
  logic [2:0]  sh_q, sh_d;
  logic [6:0]  row_q, row_d;
  logic [7:0]  spr_q, spr_d;
  logic [11:0] spr_addr_q, spr_addr_d;
  logic [9:0]  fb_addr_q, fb_addr_d;
  logic [7:0]  fb_wdata_q, fb_wdata_d;
  logic        fb_we_q, fb_we_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        collision_q, collision_d;

  logic [5:0]  x_mod;
  logic [4:0]  y_mod;
  logic [7:0]  lmask, rmask;
  logic [3:0]  rcol_raw, rcol;
  logic        right_go;
  logic        next_row;

  logic [3:0]  plan_r, plan_n;
  logic [4:0]  plan_y0;
  logic [11:0] plan_i;
  logic [6:0]  plan_yr, plan_row;
  logic        plan_go;

  function automatic logic [9:0] byte_addr(input logic [6:0] row, input logic [3:0] col);
    return 10'(FB_BASE + int'(row) * ROW_BYTES + int'(col));
  endfunction

  assign x_mod = 6'(int'(x) % FB_W);
  assign y_mod = 5'(int'(y) % FB_H);

  assign lmask = spr_q >> sh_q;
  assign rmask = spr_q << (4'd8 - {1'b0, sh_q});

  assign rcol_raw = {1'b0, col_q} + 4'd1;
  assign rcol     = (int'(rcol_raw) < ROW_BYTES) ? rcol_raw : 4'd0;
  assign right_go = (sh_q != 3'd0) && ((int'(rcol_raw) < ROW_BYTES) || WRAP);

  // Row planner: in IDLE it looks at the incoming command (row 0), otherwise
  // at the latched command (row r+1). An off-screen row ends a clipped draw.
  always_comb begin
    if (state_q == S_IDLE) begin
      plan_r  = 4'd0;
      plan_n  = n;
      plan_y0 = y_mod;
      plan_i  = i_addr;
    end else begin
      plan_r  = r_q + 4'd1;
      plan_n  = n_q;
      plan_y0 = y0_q;
      plan_i  = i_q;
    end
    plan_yr  = 7'(plan_y0) + 7'(plan_r);
    plan_row = 7'(int'(plan_yr) % FB_H);
    plan_go  = (plan_r < plan_n) && ((int'(plan_yr) < FB_H) || WRAP);
  end

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d     = state_q;
    i_d         = i_q;
    n_d         = n_q;
    r_d         = r_q;
    y0_d        = y0_q;
    col_d       = col_q;
    sh_d        = sh_q;
    row_d       = row_q;
    spr_d       = spr_q;
    spr_addr_d  = spr_addr_q;
    fb_addr_d   = fb_addr_q;
    fb_wdata_d  = fb_wdata_q;
    fb_we_d     = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    collision_d = collision_q;
    next_row    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (clear) begin
          state_d     = S_CLR;
          busy_d      = 1'b1;
          collision_d = 1'b0;
          fb_we_d     = 1'b1;
          fb_wdata_d  = 8'h00;
          fb_addr_d   = CLR_FIRST;
        end else if (start) begin
          collision_d = 1'b0;
          i_d         = i_addr;
          n_d         = n;
          y0_d        = y_mod;
          col_d       = x_mod[5:3];
          sh_d        = x_mod[2:0];
          next_row    = 1'b1;
        end
      end
      S_CLR: begin
        if (fb_addr_q == CLR_LAST) begin
          state_d = S_FIN;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          fb_we_d   = 1'b1;
          fb_addr_d = fb_addr_q + 10'd1;
        end
      end
      S_ROW_FETCH: state_d = S_ROW_WAIT;
      S_ROW_WAIT: begin
        spr_d     = spr_data;
        fb_addr_d = byte_addr(row_q, {1'b0, col_q});
        state_d   = S_L_RD;
      end
      S_L_RD: state_d = S_L_WAIT;
      S_L_WAIT: begin
        state_d     = S_L_WR;
        fb_we_d     = 1'b1;
        fb_wdata_d  = fb_rdata ^ lmask;
        collision_d = collision_q | (|(fb_rdata & lmask));
      end
      S_L_WR: begin
        if (right_go) begin
          state_d   = S_R_RD;
          fb_addr_d = byte_addr(row_q, rcol);
        end else begin
          next_row = 1'b1;
        end
      end
      S_R_RD: state_d = S_R_WAIT;
      S_R_WAIT: begin
        state_d     = S_R_WR;
        fb_we_d     = 1'b1;
        fb_wdata_d  = fb_rdata ^ rmask;
        collision_d = collision_q | (|(fb_rdata & rmask));
      end
      S_R_WR: next_row = 1'b1;
      S_FIN:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (next_row) begin
      if (plan_go) begin
        state_d    = S_ROW_FETCH;
        busy_d     = 1'b1;
        r_d        = plan_r;
        row_d      = plan_row;
        spr_addr_d = plan_i + 12'(plan_r);
      end else begin
        state_d = S_FIN;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      i_q         <= '0;
      n_q         <= '0;
      r_q         <= '0;
      y0_q        <= '0;
      col_q       <= '0;
      sh_q        <= '0;
      row_q       <= '0;
      spr_q       <= '0;
      spr_addr_q  <= '0;
      fb_addr_q   <= '0;
      fb_wdata_q  <= '0;
      fb_we_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      collision_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      n_q         <= n_d;
      r_q         <= r_d;
      y0_q        <= y0_d;
      col_q       <= col_d;
      sh_q        <= sh_d;
      row_q       <= row_d;
      spr_q       <= spr_d;
      spr_addr_q  <= spr_addr_d;
      fb_addr_q   <= fb_addr_d;
      fb_wdata_q  <= fb_wdata_d;
      fb_we_q     <= fb_we_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      collision_q <= collision_d;
    end
  end

  assign spr_addr  = spr_addr_q;
  assign fb_addr   = fb_addr_q;
  assign fb_wdata  = fb_wdata_q;
  assign fb_we     = fb_we_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign collision = collision_q;

endmodule

// File: tb/tb_chip8_sprite_blitter.sv
// Directed bench for chip8_sprite_blitter: one clipping and one wrapping instance,
// each with its own sprite/framebuffer RAM model; expected values are hand-computed.
module tb_chip8_sprite_blitter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, clear;
  logic [5:0]  x;
  logic [4:0]  y;
  logic [3:0]  n;
  logic [11:0] i_addr;

  logic [11:0] spr_addr0, spr_addr1;
  logic [7:0]  spr_data0, spr_data1;
  logic [9:0]  fb_addr0, fb_addr1;
  logic [7:0]  fb_rdata0, fb_rdata1;
  logic [7:0]  fb_wdata0, fb_wdata1;
  logic        fb_we0, fb_we1;
  logic        busy0, busy1, done0, done1, coll0, coll1;

  logic [7:0]  smem [4096];
  logic [7:0]  fb0 [256];
  logic [7:0]  fb1 [256];
  logic        fill_req = 1'b0;
  logic [7:0]  fill_val = 8'h00;
  int          cyc = 0;
  int          wr0 = 0;
  int          wr1 = 0;
  logic        saw401 = 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  int cyc_s;

  always #5 clk = ~clk;

  chip8_sprite_blitter #(.FB_W(64), .FB_H(32), .FB_BASE(0), .WRAP(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear), .x(x), .y(y), .n(n),
    .i_addr(i_addr), .spr_addr(spr_addr0), .spr_data(spr_data0), .fb_addr(fb_addr0),
    .fb_rdata(fb_rdata0), .fb_wdata(fb_wdata0), .fb_we(fb_we0), .busy(busy0),
    .done(done0), .collision(coll0)
  );

  chip8_sprite_blitter #(.FB_W(64), .FB_H(32), .FB_BASE(0), .WRAP(1'b1)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear), .x(x), .y(y), .n(n),
    .i_addr(i_addr), .spr_addr(spr_addr1), .spr_data(spr_data1), .fb_addr(fb_addr1),
    .fb_rdata(fb_rdata1), .fb_wdata(fb_wdata1), .fb_we(fb_we1), .busy(busy1),
    .done(done1), .collision(coll1)
  );

  // Synchronous-read RAM models plus write counters and a bulk fill port.
  always @(posedge clk) begin
    cyc       <= cyc + 1;
    spr_data0 <= smem[spr_addr0];
    spr_data1 <= smem[spr_addr1];
    fb_rdata0 <= fb0[fb_addr0[7:0]];
    fb_rdata1 <= fb1[fb_addr1[7:0]];
    if (spr_addr0 == 12'h401) saw401 <= 1'b1;
    if (fill_req) begin
      for (int i = 0; i < 256; i++) begin
        fb0[i] <= fill_val;
        fb1[i] <= fill_val;
      end
    end else begin
      if (fb_we0) begin
        fb0[fb_addr0[7:0]] <= fb_wdata0;
        wr0 <= wr0 + 1;
      end
      if (fb_we1) begin
        fb1[fb_addr1[7:0]] <= fb_wdata1;
        wr1 <= wr1 + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic int nonzero(input bit which);
    int cnt = 0;
    for (int i = 0; i < 256; i++)
      if ((which ? fb1[i] : fb0[i]) != 8'h00) cnt++;
    return cnt;
  endfunction

  task automatic fill(input logic [7:0] v);
    @(negedge clk);
    fill_req = 1'b1;
    fill_val = v;
    @(negedge clk);
    fill_req = 1'b0;
  endtask

  // Drives one command for exactly one cycle; cycle 1 is the cycle after acceptance.
  task automatic do_pulse(input logic s, input logic c, input logic [5:0] xx,
                          input logic [4:0] yy, input logic [3:0] nn, input logic [11:0] ii);
    @(negedge clk);
    start  = s;
    clear  = c;
    x      = xx;
    y      = yy;
    n      = nn;
    i_addr = ii;
    cyc_s  = cyc;
    @(negedge clk);
    start = 1'b0;
    clear = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int k = 0; k < 1000; k++) begin
      if (done0) begin
        lat = cyc - cyc_s;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    int lat, lat1, w0, w1, bad;

    rst_n = 1'b0; start = 1'b0; clear = 1'b0;
    x = '0; y = '0; n = '0; i_addr = '0;
    for (int i = 0; i < 4096; i++) smem[i] = 8'h00;
    smem[12'h200] = 8'hF0;
    smem[12'h300] = 8'hFF;
    smem[12'h301] = 8'h81;
    smem[12'h400] = 8'hC0;
    smem[12'h401] = 8'hC0;

    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_done", 32'(done0), 32'd0);
    check("rst_we", 32'(fb_we0), 32'd0);
    check("rst_coll", 32'(coll0), 32'd0);
    check("rst_addrs", {10'd0, fb_addr0, spr_addr0}, 32'd0);
    check("rst_wdata", 32'(fb_wdata0), 32'd0);
    rst_n = 1'b1;

    // Single byte at the origin, then the same draw again erases it.
    fill(8'h00);
    w0 = wr0;
    do_pulse(1'b1, 1'b0, 6'd0, 5'd0, 4'd1, 12'h200);
    check("t3_busy", 32'(busy0), 32'd1);
    wait_done(lat);
    check("t3_lat", 32'(lat), 32'd6);
    check("t3_coll", 32'(coll0), 32'd0);
    @(negedge clk);
    check("t3_b0", 32'(fb0[0]), 32'hF0);
    check("t3_b1", 32'(fb0[1]), 32'h00);
    check("t3_writes", 32'(wr0 - w0), 32'd1);
    check("t3_busy_end", 32'(busy0), 32'd0);
    do_pulse(1'b1, 1'b0, 6'd0, 5'd0, 4'd1, 12'h200);
    wait_done(lat);
    check("t3r_lat", 32'(lat), 32'd6);
    check("t3r_coll", 32'(coll0), 32'd1);
    @(negedge clk);
    check("t3r_b0", 32'(fb0[0]), 32'h00);

    // n=0 does nothing but still clears collision.
    w0 = wr0;
    do_pulse(1'b1, 1'b0, 6'd5, 5'd5, 4'd0, 12'h200);
    wait_done(lat);
    check("n0_lat", 32'(lat), 32'd1);
    check("n0_coll", 32'(coll0), 32'd0);
    check("n0_writes", 32'(wr0 - w0), 32'd0);

    // Two rows straddling a byte boundary.
    fill(8'h00);
    w0 = wr0;
    do_pulse(1'b1, 1'b0, 6'd3, 5'd2, 4'd2, 12'h300);
    wait_done(lat);
    check("t4_lat", 32'(lat), 32'd17);
    @(negedge clk);
    check("t4_a16", 32'(fb0[16]), 32'h1F);
    check("t4_a17", 32'(fb0[17]), 32'hE0);
    check("t4_a24", 32'(fb0[24]), 32'h10);
    check("t4_a25", 32'(fb0[25]), 32'h20);
    check("t4_writes", 32'(wr0 - w0), 32'd4);
    check("t4_coll", 32'(coll0), 32'd0);

    // Reset asserted during R_WAIT of row 0.
    fill(8'h00);
    w0 = wr0;
    do_pulse(1'b1, 1'b0, 6'd3, 5'd2, 4'd2, 12'h300);
    repeat (6) @(negedge clk);
    check("t1_raddr", 32'(fb_addr0), 32'd17);
    check("t1_rwe", 32'(fb_we0), 32'd0);
    rst_n = 1'b0;
    #1;
    check("t1_busy", 32'(busy0), 32'd0);
    check("t1_we", 32'(fb_we0), 32'd0);
    w1 = wr0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("t1_pre_writes", 32'(w1 - w0), 32'd1);
    check("t1_post_writes", 32'(wr0 - w1), 32'd0);
    check("t1_a16", 32'(fb0[16]), 32'h1F);
    check("t1_a17", 32'(fb0[17]), 32'h00);

    // CLS over a full buffer, after a draw that left collision set.
    fill(8'hFF);
    do_pulse(1'b1, 1'b0, 6'd0, 5'd0, 4'd1, 12'h200);
    wait_done(lat);
    check("t2_pre_coll", 32'(coll0), 32'd1);
    w0 = wr0;
    do_pulse(1'b0, 1'b1, 6'd0, 5'd0, 4'd0, 12'h000);
    check("t2_busy", 32'(busy0), 32'd1);
    bad = 0;
    for (int k = 1; k <= 256; k++) begin
      if (!fb_we0 || fb_addr0 != 10'(k - 1) || fb_wdata0 != 8'h00 || done0) bad++;
      @(negedge clk);
    end
    check("t2_seq", 32'(bad), 32'd0);
    check("t2_done257", 32'(done0), 32'd1);
    check("t2_we_end", 32'(fb_we0), 32'd0);
    check("t2_coll", 32'(coll0), 32'd0);
    check("t2_writes", 32'(wr0 - w0), 32'd256);
    check("t2_nonzero", 32'(nonzero(1'b0)), 32'd0);

    // Bottom-right corner: clipped on one instance, wrapped on the other.
    fill(8'h00);
    w0 = wr0;
    w1 = wr1;
    do_pulse(1'b1, 1'b0, 6'd62, 5'd31, 4'd2, 12'h400);
    lat = -1;
    lat1 = -1;
    for (int k = 0; k < 400 && (lat < 0 || lat1 < 0); k++) begin
      if (done0 && lat < 0) lat = cyc - cyc_s;
      if (done1 && lat1 < 0) lat1 = cyc - cyc_s;
      @(negedge clk);
    end
    check("t5c_lat", 32'(lat), 32'd6);
    check("t5c_a255", 32'(fb0[255]), 32'h03);
    check("t5c_nonzero", 32'(nonzero(1'b0)), 32'd1);
    check("t5c_writes", 32'(wr0 - w0), 32'd1);
    check("t5c_no_row1_fetch", 32'(saw401), 32'd0);
    check("t5w_lat", 32'(lat1), 32'd17);
    check("t5w_a255", 32'(fb1[255]), 32'h03);
    check("t5w_a7", 32'(fb1[7]), 32'h03);
    check("t5w_nonzero", 32'(nonzero(1'b1)), 32'd2);
    check("t5w_writes", 32'(wr1 - w1), 32'd4);

    // Start while busy is ignored; start together with clear performs CLS only.
    fill(8'hFF);
    w0 = wr0;
    do_pulse(1'b1, 1'b0, 6'd0, 5'd0, 4'd1, 12'h200);
    @(negedge clk);
    start = 1'b1;
    x     = 6'd8;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    check("t6_lat", 32'(lat), 32'd6);
    @(negedge clk);
    check("t6_a0", 32'(fb0[0]), 32'h0F);
    check("t6_a1", 32'(fb0[1]), 32'hFF);
    check("t6_writes", 32'(wr0 - w0), 32'd1);
    check("t6_coll", 32'(coll0), 32'd1);
    w0 = wr0;
    do_pulse(1'b1, 1'b1, 6'd8, 5'd0, 4'd1, 12'h200);
    wait_done(lat);
    check("t6b_lat", 32'(lat), 32'd257);
    check("t6b_coll", 32'(coll0), 32'd0);
    check("t6b_writes", 32'(wr0 - w0), 32'd256);
    check("t6b_nonzero", 32'(nonzero(1'b0)), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
